// File: rtl/ads5281_pll.sv
// ads5281_pll
//
// Clock generator for the ADS5281 serial-link model. It divides the
// reference clock inclk0 into three 50 %-duty clocks that are aligned in
// phase:
//   c0 : sample/frame clock, inclk0 / C0_DIV
//   c1 : DDR bit-pair clock (LCLK), inclk0 / C1_DIV
//   c2 : serializer bit clock, inclk0 / C2_DIV
// The block also has a lock flag. It asserts after LOCK_CYCLES non-reset
// edges and stays high until the next reset.
//
// Ports
//   inclk0 : in  : reference clock. All state changes on its rising edge.
//   areset : in  : synchronous, active-high reset.
//   c0     : out : frame clock. It is a register.
//   c1     : out : LCLK. It is a register.
//   c2     : out : bit clock. It is a register.
//   locked : out : lock flag. It is a register.
//
// Parameter constraints:
//   - C0_DIV, C1_DIV and C2_DIV must be even.
//   - C0_DIV must be a multiple of C1_DIV and of C2_DIV.
//   - LOCK_CYCLES must be at least 1.

module ads5281_pll #(
    parameter int C0_DIV      = 24,
    parameter int C1_DIV      = 4,
    parameter int C2_DIV      = 2,
    parameter int LOCK_CYCLES = 48
) (
    input  logic inclk0,
    input  logic areset,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic locked
);

    localparam int P_W  = (C0_DIV > 2) ? $clog2(C0_DIV) : 1;
    localparam int Q1_W = (C1_DIV > 2) ? $clog2(C1_DIV) : 1;
    localparam int Q2_W = (C2_DIV > 2) ? $clog2(C2_DIV) : 1;
    localparam int L_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [P_W-1:0]  P_LAST  = P_W'(C0_DIV - 1);
    localparam logic [P_W-1:0]  P_HALF  = P_W'(C0_DIV / 2);
    localparam logic [Q1_W-1:0] Q1_LAST = Q1_W'(C1_DIV - 1);
    localparam logic [Q1_W-1:0] Q1_HALF = Q1_W'(C1_DIV / 2);
    localparam logic [Q2_W-1:0] Q2_LAST = Q2_W'(C2_DIV - 1);
    localparam logic [Q2_W-1:0] Q2_HALF = Q2_W'(C2_DIV / 2);
    localparam logic [L_W-1:0]  L_MAX   = L_W'(LOCK_CYCLES);
    localparam logic [L_W-1:0]  L_PRE   = L_W'(LOCK_CYCLES - 1);

    // r_p is the frame phase. r_q1 and r_q2 hold p mod C1_DIV and
    // p mod C2_DIV. They are kept as separate counters so no divider is needed.
    logic [P_W-1:0]  r_p;
    logic [Q1_W-1:0] r_q1;
    logic [Q2_W-1:0] r_q2;
    logic [L_W-1:0]  r_lock_cnt;
    logic            r_c0;
    logic            r_c1;
    logic            r_c2;
    logic            r_locked;

    logic w_p_wrap;
    logic w_q1_wrap;
    logic w_q2_wrap;

    assign w_p_wrap  = (r_p  == P_LAST);
    assign w_q1_wrap = (r_q1 == Q1_LAST);
    assign w_q2_wrap = (r_q2 == Q2_LAST);

    always_ff @(posedge inclk0) begin
        if (areset) begin
            r_p        <= '0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_c0       <= 1'b0;
            r_c1       <= 1'b0;
            r_c2       <= 1'b0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_c0 <= (r_p  < P_HALF);
            r_c1 <= (r_q1 < Q1_HALF);
            r_c2 <= (r_q2 < Q2_HALF);

            r_p  <= w_p_wrap ? '0 : r_p + 1'b1;
            // The sub-counters also restart on the frame wrap. Every frame
            // therefore begins with all three clocks rising together.
            r_q1 <= (w_p_wrap || w_q1_wrap) ? '0 : r_q1 + 1'b1;
            r_q2 <= (w_p_wrap || w_q2_wrap) ? '0 : r_q2 + 1'b1;

            // The lock counter saturates at LOCK_CYCLES. locked is set on the
            // edge where the counter reaches that value, and then holds.
            if (r_lock_cnt != L_MAX) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
            if (r_lock_cnt == L_PRE) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign c0     = r_c0;
    assign c1     = r_c1;
    assign c2     = r_c2;
    assign locked = r_locked;

endmodule

// File: tb/tb_ads5281_pll.sv
// tb_ads5281_pll
//
// Bench for ads5281_pll. It runs the default instance and a second instance
// with overridden parameters (48/8/4, lock after 4). For each instance a
// reference model is written from the clock equations. The model pushes the
// expected {c0,c1,c2,locked} for every edge into a queue, and the values are
// compared on the falling edge. Directed checks cover these items against
// hand-computed numbers:
//   - reset values
//   - the first edge after release
//   - rising-edge counts
//   - high/low run lengths
//   - phase alignment
//   - the lock edge
//   - reset in the middle of a frame

module tb_ads5281_pll;

    logic inclk0 = 1'b0;
    logic areset = 1'b1;
    logic c0_a, c1_a, c2_a, lk_a;
    logic c0_b, c1_b, c2_b, lk_b;
    logic [3:0] w_a, w_b;

    assign w_a = {c0_a, c1_a, c2_a, lk_a};
    assign w_b = {c0_b, c1_b, c2_b, lk_b};

    ads5281_pll dut_a (
        .inclk0 (inclk0),
        .areset (areset),
        .c0     (c0_a),
        .c1     (c1_a),
        .c2     (c2_a),
        .locked (lk_a)
    );

    ads5281_pll #(
        .C0_DIV      (48),
        .C1_DIV      (8),
        .C2_DIV      (4),
        .LOCK_CYCLES (4)
    ) dut_b (
        .inclk0 (inclk0),
        .areset (areset),
        .c0     (c0_b),
        .c1     (c1_b),
        .c2     (c2_b),
        .locked (lk_b)
    );

    // ---------------- clock / watchdog ----------------
    always #5 inclk0 = ~inclk0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    int div0  [2] = '{24, 48};
    int div1  [2] = '{4, 8};
    int div2  [2] = '{2, 4};
    int lockc [2] = '{48, 4};
    int half  [2][3] = '{'{12, 2, 1}, '{24, 4, 2}};

    int m_p    [2] = '{0, 0};
    int m_lock [2] = '{0, 0};
    logic [3:0] m_e;
    logic [3:0] exp_q_a [$];
    logic [3:0] exp_q_b [$];

    always @(posedge inclk0) begin
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                m_p[d]    = 0;
                m_lock[d] = 0;
                m_e       = 4'b0000;
            end else begin
                if (m_lock[d] < lockc[d]) m_lock[d]++;
                m_e = {(m_p[d] < div0[d] / 2),
                       ((m_p[d] % div1[d]) < div1[d] / 2),
                       ((m_p[d] % div2[d]) < div2[d] / 2),
                       (m_lock[d] >= lockc[d])};
                m_p[d] = (m_p[d] + 1) % div0[d];
            end
            if (d == 0) exp_q_a.push_back(m_e);
            else        exp_q_b.push_back(m_e);
        end
    end

    always @(negedge inclk0) begin
        if (exp_q_a.size() > 0) check("sb_a", 32'(w_a), 32'(exp_q_a.pop_front()));
        if (exp_q_b.size() > 0) check("sb_b", 32'(w_b), 32'(exp_q_b.pop_front()));
    end

    // ---------------- waveform statistics ----------------
    int         since_rel;
    int         rise        [2][3];
    int         run_len     [2][3];
    bit         run_ok      [2][3];
    int         misalign    [2];
    int         bad_run     [2];
    int         between_bad [2];
    int         c2_cnt      [2];
    bit         c0_seen     [2];
    int         lock_at     [2];
    int         locked_drop [2];
    logic [3:0] prev        [2];

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) rise[d][k] = 0;
            misalign[d]    = 0;
            bad_run[d]     = 0;
            between_bad[d] = 0;
            locked_drop[d] = 0;
        end
    endtask

    task automatic sample();
        logic [3:0] cur [2];
        bit r0, r1, r2;
        cur[0] = w_a;
        cur[1] = w_b;
        if (areset) since_rel = 0;
        else        since_rel++;
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                lock_at[d] = -1;
                c0_seen[d] = 1'b0;
                c2_cnt[d]  = 0;
                for (int k = 0; k < 3; k++) begin
                    run_ok[d][k]  = 1'b0;
                    run_len[d][k] = 0;
                end
            end else begin
                r0 = cur[d][3] && !prev[d][3];
                r1 = cur[d][2] && !prev[d][2];
                r2 = cur[d][1] && !prev[d][1];
                if (r0) rise[d][0]++;
                if (r1) rise[d][1]++;
                if (r2) rise[d][2]++;
                if (r0 && !(r1 && r2)) misalign[d]++;
                if (r1 && !r2)         misalign[d]++;
                if (r0) begin
                    if (c0_seen[d] && c2_cnt[d] != div0[d] / div2[d]) between_bad[d]++;
                    c2_cnt[d]  = 0;
                    c0_seen[d] = 1'b1;
                end
                if (r2) c2_cnt[d]++;
                for (int k = 0; k < 3; k++) begin
                    if (cur[d][3-k] == prev[d][3-k]) begin
                        run_len[d][k]++;
                    end else begin
                        if (run_ok[d][k] && run_len[d][k] != half[d][k]) bad_run[d]++;
                        run_ok[d][k]  = 1'b1;
                        run_len[d][k] = 1;
                    end
                end
                if (cur[d][0] && lock_at[d] < 0) lock_at[d] = since_rel;
                if (lock_at[d] >= 0 && !cur[d][0]) locked_drop[d]++;
            end
            prev[d] = cur[d];
        end
    endtask

    // ---------------- driver ----------------
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge inclk0);
            sample();
        end
    endtask

    task automatic check_release_window(input string pfx);
        // This check covers the first 48 edges after release.
        // Instance a (24/4/2): 2 c0 rises, 12 c1 rises and 24 c2 rises.
        // Instance b (48/8/4): 1 c0 rise, 6 c1 rises and 12 c2 rises.
        check({pfx, "_rise_c0_a"}, 32'(rise[0][0]), 2);
        check({pfx, "_rise_c1_a"}, 32'(rise[0][1]), 12);
        check({pfx, "_rise_c2_a"}, 32'(rise[0][2]), 24);
        check({pfx, "_rise_c0_b"}, 32'(rise[1][0]), 1);
        check({pfx, "_rise_c1_b"}, 32'(rise[1][1]), 6);
        check({pfx, "_rise_c2_b"}, 32'(rise[1][2]), 12);
        check({pfx, "_runs_a"},    32'(bad_run[0]), 0);
        check({pfx, "_runs_b"},    32'(bad_run[1]), 0);
        check({pfx, "_align_a"},   32'(misalign[0]), 0);
        check({pfx, "_align_b"},   32'(misalign[1]), 0);
        check({pfx, "_lock_at_a"}, 32'(lock_at[0]), 48);
        check({pfx, "_lock_at_b"}, 32'(lock_at[1]), 4);
    endtask

    initial begin
        since_rel = 0;
        lock_at   = '{-1, -1};
        prev      = '{4'b0000, 4'b0000};
        c0_seen   = '{1'b0, 1'b0};
        c2_cnt    = '{0, 0};
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                run_ok[d][k]  = 1'b0;
                run_len[d][k] = 0;
            end
        end
        clear_stats();

        // Reset held for 5 cycles: all outputs stay 0.
        areset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run(1);
            check("rst_a", 32'(w_a), 0);
            check("rst_b", 32'(w_b), 0);
        end

        // Release: the first edge drives all three clocks high.
        areset = 1'b0;
        clear_stats();
        run(1);
        check("first_a", 32'(w_a[3:1]), 7);
        check("first_b", 32'(w_b[3:1]), 7);
        check("first_lk_a", 32'(w_a[0]), 0);
        run(47);
        check_release_window("rel");

        // Phase alignment over 10 frames of instance a (240 edges).
        // Instance b covers 5 frames in the same window.
        clear_stats();
        run(240);
        check("p3_rise_c0_a", 32'(rise[0][0]), 10);
        check("p3_rise_c2_a", 32'(rise[0][2]), 120);
        check("p3_align_a",   32'(misalign[0]), 0);
        check("p3_between_a", 32'(between_bad[0]), 0);
        check("p3_runs_a",    32'(bad_run[0]), 0);
        check("p3_rise_c0_b", 32'(rise[1][0]), 5);
        check("p3_rise_c1_b", 32'(rise[1][1]), 30);
        check("p3_rise_c2_b", 32'(rise[1][2]), 60);
        check("p3_align_b",   32'(misalign[1]), 0);
        check("p3_between_b", 32'(between_bad[1]), 0);

        // locked holds for 1000 further cycles.
        clear_stats();
        run(1000);
        check("hold_lock_a", 32'(locked_drop[0]), 0);
        check("hold_lock_b", 32'(locked_drop[1]), 0);
        check("hold_lk_a",   32'(w_a[0]), 1);

        // Reset in the middle of a frame: the next edge of instance a uses p=7.
        for (int i = 0; i < 30 && m_p[0] != 7; i++) run(1);
        check("find_p7", 32'(m_p[0]), 7);
        areset = 1'b1;
        run(1);
        check("mid_rst_a", 32'(w_a), 0);
        check("mid_rst_b", 32'(w_b), 0);
        areset = 1'b0;
        clear_stats();
        run(1);
        check("mid_first_a", 32'(w_a[3:1]), 7);
        check("mid_first_b", 32'(w_b[3:1]), 7);
        run(47);
        check_release_window("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
